instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Sequential RISC-V RV32I instruction encoder and program loader. It accepts instruction field tuples over a valid/ready handshake and packs each one into a 32-bit instruction word. Supported classes are R-type ALU, I-type ALU, load, store and branch. Each word is written to consecutive instruction-memory word addresses. The block sits in front of the single-cycle core's instruction memory, and the words it writes are exactly the ones the core's main decoder classifies.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load session
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept a tuple
- in_kind  in  3  instruction class: 0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch. Values 5–7 are illegal.
- in_funct3  in  3  funct3 field
- in_funct7b5  in  1  R-type funct7 bit 5; used only for kind 0
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  13  signed immediate. I, load and store use [11:0]. Branch uses [12:1], and [0] is ignored.
- in_last  in  1  marks the final tuple of the session
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- done  out  1  session finished
- full  out  1  memory capacity reached before in_last
- err  out  1  sticky flag: an illegal in_kind was seen this session

## Operation
Encoding of mem_wdata:
- Kind 0: {in_funct7b5 ? 7'b0100000 : 7'b0, rs2, rs1, f3, rd, 7'b0110011}
- Kind 1: {imm[11:0], rs1, f3, rd, 7'b0010011}
- Kind 2: {imm[11:0], rs1, f3, rd, 7'b0000011}
- Kind 3: {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011}
- Kind 4: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}
- Unused fields for a kind are ignored.

FSM states:
- IDLE:
  - in_ready=0.
  - start → addr=0, count=0, err=0, full=0, done=0; next state LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: latch the encoded word into mem_wdata and latch in_last.
  - Legal kind → WRITE.
  - Illegal kind → set err and write nothing. Next state is DONE if in_last, otherwise stay in LOAD.
- WRITE:
  - in_ready=0, mem_we=1 for exactly this cycle, with mem_addr=addr.
  - At the clock edge: addr+1 and count+1.
  - Latched last → DONE.
  - Else if addr was 2^ADDR_W−1 → set full; next state DONE.
  - Else → LOAD.
- DONE:
  - done=1, in_ready=0.
  - start → same initialisation as in IDLE; next state LOAD.

Boundary rules:
- start is ignored in LOAD and WRITE.
- in_last arriving on the final address is a normal completion: full stays 0.
- addr wraps to 0 internally after the last word. It is never written while full=1.
- count saturates naturally at 2^ADDR_W (it is ADDR_W+1 bits wide).
- Asynchronous reset mid-session forces IDLE immediately. The partial word is not written.

## Timing
- Reset values: state IDLE; in_ready, mem_we, done, full, err all 0; mem_addr=0; mem_wdata=0; count=0.
- Outputs:
  - in_ready and mem_we decode from the state register; no combinational path from inputs.
  - mem_addr, mem_wdata, count, done, full and err are registered.
- Latency and throughput:
  - Accepting a tuple at edge N → mem_we high during cycle N+1, written at edge N+1.
  - Throughput is one instruction per 2 cycles.
- done rises the cycle after the final WRITE, or after an illegal last tuple.
- A tuple is accepted only in a cycle where in_valid and in_ready are both high. The upstream holds fields stable while in_valid=1 and in_ready=0.

## Test plan
- addi x1,x0,5: start, then kind 1, f3=0, rd=1, rs1=0, imm=5, last=1.
  - Expect mem_we one cycle later with addr 0 and data 0x00500093.
  - Then done=1 and count=1.
- add x3,x1,x2 followed by sub x3,x1,x2 (funct7b5=1), back-to-back valid.
  - Expect 0x002081B3 at addr 0 and 0x402081B3 at addr 1.
  - in_ready low during each WRITE; count=2.
- lw x5,8(x2), sw x5,12(x2), then beq x1,x2,-4 (imm=13'h1FFC) with last.
  - Expect 0x00812283, 0x00512623 and 0xFE208EE3 at addrs 0–2.
- Illegal kind 6 mid-stream between two legal tuples.
  - Expect err=1, no mem_we for the illegal tuple, and the two legal words at addrs 0 and 1.
- With ADDR_W=2, send 5 tuples without last.
  - Expect 4 writes (addr 0–3), then full=1, done=1, count=4.
  - The fifth tuple is never accepted.
- Assert rst_n low in the WRITE cycle of the second tuple.
  - Expect all outputs to return to reset values immediately.
  - After release, a new start must write from addr 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs RV32I field tuples (R-ALU, I-ALU, load, store, branch) into 32-bit
// instruction words. The words go to consecutive instruction-memory addresses,
// starting at 0 in each load session.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                pulse that opens a load session (IDLE/DONE only)
//   in_valid / in_ready  tuple handshake
//   in_kind .. in_last   tuple fields (kind 5..7 illegal)
//   mem_we/addr/wdata    instruction-memory write port
//   count                words written this session
//   done, full, err      session status (err is sticky per session)
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | ready for a tuple
// WRITE | one-cycle memory write of the latched word
// DONE  | session finished, waiting for start
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic [31:0]         enc_word;
    logic                kind_legal;

    always_comb begin
        enc_word   = 32'h0;
        kind_legal = 1'b1;
        case (in_kind)
            3'd0: enc_word = {in_funct7b5 ? 7'b0100000 : 7'b0000000, in_rs2, in_rs1,
                              in_funct3, in_rd, 7'b0110011};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                              7'b0100011};
            3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            default: kind_legal = 1'b0;
        endcase
    end

    // Handshake and write strobe come straight from the state register.
    assign in_ready  = (state_q == LOAD);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign full      = full_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (kind_legal) begin
                        wdata_d = enc_word;
                        last_d  = in_last;
                        state_d = WRITE;
                    end else begin
                        // Illegal tuple is consumed but never written.
                        err_d = 1'b1;
                        if (in_last) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    // Capacity exhausted without in_last; addr has wrapped to 0.
                    full_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        in_valid;
    logic [2:0]  in_kind, in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;
    logic        in_last;

    logic        in_ready_a, mem_we_a, done_a, full_a, err_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  count_a;

    logic        in_ready_b, mem_we_b, done_b, full_b, err_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  count_b;

    logic        use_b;
    logic        rdy;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [31:0] qb_addr[$];

    always #5 clk = ~clk;

    assign rdy = use_b ? in_ready_b : in_ready_a;

    instr_encoder_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_kind(in_kind), .in_funct3(in_funct3),
        .in_funct7b5(in_funct7b5), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .count(count_a), .done(done_a), .full(full_a),
        .err(err_a)
    );

    instr_encoder_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_kind(in_kind), .in_funct3(in_funct3),
        .in_funct7b5(in_funct7b5), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .count(count_b), .done(done_b), .full(full_b),
        .err(err_b)
    );

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we_a) begin
            qa_addr.push_back({24'h0, mem_addr_a});
            qa_data.push_back(mem_wdata_a);
        end
        if (mem_we_b) qb_addr.push_back({30'h0, mem_addr_b});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Returns in the cycle right after the tuple was accepted.
    task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [12:0] imm, input logic last);
        int n;
        in_kind = k; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!rdy && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("send_timeout", {63'h0, rdy}, 64'h1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; use_b = 1'b0;
        in_valid = 1'b0; in_kind = 3'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'd0; in_last = 1'b0;
        #3;
        chk("rst_ready", {63'h0, in_ready_a}, 64'h0);
        chk("rst_we", {63'h0, mem_we_a}, 64'h0);
        chk("rst_addr", {56'h0, mem_addr_a}, 64'h0);
        chk("rst_wdata", {32'h0, mem_wdata_a}, 64'h0);
        chk("rst_count", {55'h0, count_a}, 64'h0);
        chk("rst_flags", {61'h0, done_a, full_a, err_a}, 64'h0);
        step();
        rst_n = 1'b1;
        step();

        // addi x1,x0,5
        pulse_start(1'b0);
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        chk("addi_we", {63'h0, mem_we_a}, 64'h1);
        chk("addi_addr", {56'h0, mem_addr_a}, 64'h0);
        chk("addi_data", {32'h0, mem_wdata_a}, 64'h00500093);
        step();
        chk("addi_done", {63'h0, done_a}, 64'h1);
        chk("addi_count", {55'h0, count_a}, 64'h1);
        chk("addi_we_off", {63'h0, mem_we_a}, 64'h0);

        // add / sub back-to-back
        pulse_start(1'b0);
        chk("start_clr_done", {63'h0, done_a}, 64'h0);
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("add_ready_low", {63'h0, in_ready_a}, 64'h0);
        chk("add_addr", {56'h0, mem_addr_a}, 64'h0);
        chk("add_data", {32'h0, mem_wdata_a}, 64'h002081B3);
        send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
        chk("sub_ready_low", {63'h0, in_ready_a}, 64'h0);
        chk("sub_addr", {56'h0, mem_addr_a}, 64'h1);
        chk("sub_data", {32'h0, mem_wdata_a}, 64'h402081B3);
        step();
        chk("addsub_count", {55'h0, count_a}, 64'h2);
        chk("addsub_done", {63'h0, done_a}, 64'h1);

        // lw / sw / beq
        pulse_start(1'b0);
        send(3'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
        chk("lw_data", {32'h0, mem_wdata_a}, 64'h00812283);
        send(3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 13'd12, 1'b0);
        chk("sw_data", {32'h0, mem_wdata_a}, 64'h00512623);
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1);
        chk("beq_addr", {56'h0, mem_addr_a}, 64'h2);
        chk("beq_data", {32'h0, mem_wdata_a}, 64'hFE208EE3);
        step();
        chk("lsb_count", {55'h0, count_a}, 64'h3);
        chk("lsb_err", {63'h0, err_a}, 64'h0);

        // illegal kind between two legal tuples
        pulse_start(1'b0);
        qa_addr.delete();
        qa_data.delete();
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        send(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd1, 1'b0);
        chk("ill_no_we", {63'h0, mem_we_a}, 64'h0);
        chk("ill_err", {63'h0, err_a}, 64'h1);
        chk("ill_ready", {63'h0, in_ready_a}, 64'h1);
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
        step();
        chk("ill_done", {63'h0, done_a}, 64'h1);
        chk("ill_count", {55'h0, count_a}, 64'h2);
        chk("ill_err_sticky", {63'h0, err_a}, 64'h1);
        chk("ill_nwrites", 64'(qa_addr.size()), 64'h2);
        if (qa_addr.size() == 2) begin
            chk("ill_w0_addr", {32'h0, qa_addr[0]}, 64'h0);
            chk("ill_w0_data", {32'h0, qa_data[0]}, 64'h00500093);
            chk("ill_w1_addr", {32'h0, qa_addr[1]}, 64'h1);
            chk("ill_w1_data", {32'h0, qa_data[1]}, 64'h002081B3);
        end

        // capacity: ADDR_W=2, no last
        use_b = 1'b1;
        pulse_start(1'b1);
        qb_addr.delete();
        for (int i = 0; i < 4; i++) begin
            send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'(i), 1'b0);
            chk("full_we", {63'h0, mem_we_b}, 64'h1);
            chk("full_addr", {62'h0, mem_addr_b}, 64'(i));
        end
        step();
        chk("full_flag", {63'h0, full_b}, 64'h1);
        chk("full_done", {63'h0, done_b}, 64'h1);
        chk("full_count", {61'h0, count_b}, 64'h4);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("full_no_accept", {63'h0, in_ready_b}, 64'h0);
            step();
        end
        in_valid = 1'b0;
        chk("full_count_hold", {61'h0, count_b}, 64'h4);
        chk("full_nwrites", 64'(qb_addr.size()), 64'h4);

        // last on the final address is a normal completion
        pulse_start(1'b1);
        chk("restart_full_clr", {63'h0, full_b}, 64'h0);
        for (int i = 0; i < 4; i++)
            send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'(i), (i == 3) ? 1'b1 : 1'b0);
        step();
        chk("lastfinal_full", {63'h0, full_b}, 64'h0);
        chk("lastfinal_done", {63'h0, done_b}, 64'h1);
        chk("lastfinal_count", {61'h0, count_b}, 64'h4);
        use_b = 1'b0;

        // reset during WRITE of the second tuple
        pulse_start(1'b0);
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd7, 1'b0);
        send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 13'd9, 1'b0);
        chk("prerst_we", {63'h0, mem_we_a}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", {63'h0, mem_we_a}, 64'h0);
        chk("arst_ready", {63'h0, in_ready_a}, 64'h0);
        chk("arst_addr", {56'h0, mem_addr_a}, 64'h0);
        chk("arst_wdata", {32'h0, mem_wdata_a}, 64'h0);
        chk("arst_count", {55'h0, count_a}, 64'h0);
        chk("arst_flags", {61'h0, done_a, full_a, err_a}, 64'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        pulse_start(1'b0);
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        chk("post_rst_addr", {56'h0, mem_addr_a}, 64'h0);
        chk("post_rst_data", {32'h0, mem_wdata_a}, 64'h00500093);
        step();
        chk("post_rst_count", {55'h0, count_a}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
